multiply_divide_unit: RTL and testbench
=======================================

# multiply_divide_unit

Iterative 16-bit multiply/divide unit in the execute stage of the 16-bit CPU. It runs beside `Arithmetic_Logic_Unit` and takes the same operand pair (`data_in_A`, `data_in_B`) from the ID/EX operand latch. MULT/MULTU/DIV/DIVU are too costly for the single-cycle ALU, so they run here over 17 cycles. The result goes into the HI/LO registers, which the EX/MEM result mux reads. The pipeline control stalls on `busy`.

## Interface
- WIDTH, 16, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  launch request; sampled only when `busy`=0
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- data_in_A  input  16  multiplicand / dividend
- data_in_B  input  16  multiplier / divisor
- busy  output  1  operation in progress; pipeline stalls while high
- done  output  1  one-cycle pulse: HI/LO were updated at the preceding edge
- div_zero  output  1  sticky: last completed op was a divide by zero
- hi_out  output  16  HI register (product high half / remainder)
- lo_out  output  16  LO register (product low half / quotient)

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1: latch op and operands as magnitudes (signed ops use |A| and |B|); record result signs; clear accumulator; count=0.
  - Next state is CALC.
  - If the op is a divide and B=0, next state is FIX.
- CALC does one iteration per cycle. After 16 iterations (count=15), go to FIX.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
- FIX: apply sign correction, write hi_out/lo_out, pulse done, return to IDLE.
- Arithmetic rules:
  - MULTU: {HI,LO} = A×B, 32-bit unsigned.
  - MULT: {HI,LO} = A×B, 32-bit two's complement.
  - DIVU: LO = A/B, HI = A mod B, unsigned.
  - DIV: truncates toward zero. Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A).
  - DIV 0x8000 / 0xFFFF wraps: LO=0x8000, HI=0x0000. No overflow flag.
- Divide by zero (DIVU or DIV, B=0): LO=0xFFFF, HI=A unchanged, div_zero=1.
- div_zero updates only on completion: 1 after a divide-by-zero, 0 after any other completed op.
- start while busy=1 is ignored; the operation in flight is not disturbed.
- start in the same cycle as done=1 is accepted, since the FSM is in IDLE.
- op and operands are sampled only at the launch edge. Later changes to the inputs have no effect.
- hi_out/lo_out hold their value between operations and change only at the FIX edge.

## Timing
- Reset (async, rst=0): state=IDLE. busy, done, div_zero, hi_out, lo_out, count and accumulators all 0.
- Reset in the middle of an operation abandons it. No done pulse; HI/LO read 0.
- Launch edge N (IDLE, start=1): busy=1 from N.
- Normal operation:
  - CALC edges are N+1 … N+16.
  - FIX happens in the cycle after N+16; it writes HI/LO and sets done=1 at edge N+17, clears busy, and enters IDLE.
  - done=1 for exactly one cycle, between N+17 and N+18. busy is high for 17 cycles.
  - Result is readable from N+17.
- Divide by zero: FIX in the cycle after N. HI/LO written and done=1 at edge N+1. busy high for 1 cycle.
- busy and done are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULTU A=0xFFFF, B=0xFFFF, start at edge N: busy high N..N+17. At N+17: hi_out=0xFFFE, lo_out=0x0001, done=1 for one cycle, div_zero=0.
- MULT A=0xFFFD (−3), B=0x0005: hi_out=0xFFFF, lo_out=0xFFF1 (−15). Repeat with MULTU on the same operands: hi_out=0x0004, lo_out=0xFFF1.
- DIV A=0xFFF9 (−7), B=0x0002: lo_out=0xFFFD (−3), hi_out=0xFFFF (−1). DIV A=0x8000, B=0xFFFF: lo_out=0x8000, hi_out=0x0000.
- DIVU A=0x0064, B=0x0000: done at N+1, lo_out=0xFFFF, hi_out=0x0064, div_zero=1. A following DIVU 100/7 gives lo_out=0x000E, hi_out=0x0002, div_zero=0.
- Launch MULTU 3×4, pulse start with different operands at N+5, and change data_in_A mid-run: result is hi_out=0, lo_out=0x000C, with a single done pulse at N+17. start held high through done launches the next op back-to-back.
- Launch DIVU 100/7, assert rst=0 at N+8 for one cycle: busy/done/hi_out/lo_out drop to 0 immediately. After release, a new MULTU 2×8 completes normally with lo_out=0x0010.

Source files
------------

// File: rtl/multiply_divide_unit_if.sv
// Operand/handshake/result bundle between the ID/EX operand latch, the
// pipeline control and the iterative multiply/divide unit.
interface multiply_divide_unit_if #(parameter int WIDTH = 16);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in_A;
    logic [WIDTH-1:0] data_in_B;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, data_in_A, data_in_B,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, data_in_A, data_in_B,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/multiply_divide_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: works on magnitudes for WIDTH cycles
// (shift-add or restoring divide), then applies signs and writes HI/LO.
module multiply_divide_unit #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    multiply_divide_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               a_neg, b_neg, launch_dz;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum, trial;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mag_b_d    = mag_b_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        count_d    = count_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        a_neg     = bus.op[0] & bus.data_in_A[WIDTH-1];
        b_neg     = bus.op[0] & bus.data_in_B[WIDTH-1];
        mag_a     = a_neg ? -bus.data_in_A : bus.data_in_A;
        mag_b     = b_neg ? -bus.data_in_B : bus.data_in_B;
        launch_dz = bus.op[1] && (bus.data_in_B == '0);

        // acc holds the running product high half / partial remainder;
        // sh holds the multiplier bits still to consume / dividend-into-quotient.
        add_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mag_b_q} : '0);
        trial    = {acc_q, sh_q[WIDTH-1]} - {1'b0, mag_b_q};
        prod_fix = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    mag_b_d   = mag_b;
                    sh_d      = mag_a;
                    acc_d     = '0;
                    count_d   = '0;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dz_d      = launch_dz;
                    busy_d    = 1'b1;
                    if (launch_dz) begin
                        acc_d   = bus.data_in_A;
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!op_q[1]) begin
                    acc_d = add_sum[WIDTH:1];
                    sh_d  = {add_sum[0], sh_q[WIDTH-1:1]};
                end else if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                div_zero_d = dz_q;
                state_d    = IDLE;
                if (dz_q) begin
                    hi_d = acc_q;
                    lo_d = '1;
                end else if (op_q[1]) begin
                    hi_d = rem_neg_q ? -acc_q : acc_q;
                    lo_d = neg_q ? -sh_q : sh_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            count_q    <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mag_b_q    <= mag_b_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            count_q    <= count_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed and randomized checks of the multiply/divide unit against an
// arithmetic reference model.
module tb_multiply_divide_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    multiply_divide_unit_if #(.WIDTH(16)) bus ();

    multiply_divide_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules.
    function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] eh, output logic [15:0] el, output logic ez);
        int          sa, sb, q, r;
        logic [31:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ez = 1'b0;
        case (op)
            2'd0: p = 32'(a) * 32'(b);
            2'd1: p = 32'(sa * sb);
            default: p = '0;
        endcase
        eh = p[31:16];
        el = p[15:0];
        if (op[1]) begin
            if (b == 16'h0) begin
                eh = a; el = 16'hFFFF; ez = 1'b1;
            end else if (op == 2'd2) begin
                el = a / b; eh = a % b;
            end else begin
                q = sa / sb; r = sa % sb;
                el = q[15:0]; eh = r[15:0];
            end
        end
    endfunction

    task automatic launch(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1; bus.op = op; bus.data_in_A = a; bus.data_in_B = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Count edges after launch until done; bounded.
    task automatic wait_done(output int k);
        k = 0;
        while (!bus.done && k < 40) begin
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eh, el;
        logic        ez;
        int          k;
        model(op, a, b, eh, el, ez);
        launch(op, a, b);
        chk({tag, ".busy_launch"}, 32'(bus.busy), 32'd1);
        wait_done(k);
        chk({tag, ".latency"}, 32'(k), ez ? 32'd1 : 32'd17);
        chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, ".hi"}, 32'(bus.hi_out), 32'(eh));
        chk({tag, ".lo"}, 32'(bus.lo_out), 32'(el));
        chk({tag, ".div_zero"}, 32'(bus.div_zero), 32'(ez));
        @(posedge clk); #1;
        chk({tag, ".done_1cyc"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int          k, pulses;
        logic [15:0] ra, rb;
        logic [15:0] corner [5];
        corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
        corner[3] = 16'h8000; corner[4] = 16'hFFFF;

        bus.start = 1'b0; bus.op = 2'd0; bus.data_in_A = '0; bus.data_in_B = '0;
        #12;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.div_zero", 32'(bus.div_zero), 32'd0);
        chk("reset.hi", 32'(bus.hi_out), 32'd0);
        chk("reset.lo", 32'(bus.lo_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("multu_ffff", 2'd0, 16'hFFFF, 16'hFFFF);
        run_op("mult_m3x5", 2'd1, 16'hFFFD, 16'h0005);
        run_op("multu_m3x5", 2'd0, 16'hFFFD, 16'h0005);
        run_op("div_m7d2", 2'd3, 16'hFFF9, 16'h0002);
        run_op("div_wrap", 2'd3, 16'h8000, 16'hFFFF);
        run_op("divu_zero", 2'd2, 16'h0064, 16'h0000);
        run_op("divu_100d7", 2'd2, 16'h0064, 16'h0007);
        run_op("div_zero_s", 2'd3, 16'hFFF9, 16'h0000);
        run_op("div_after_dz", 2'd3, 16'h0007, 16'hFFFE);

        // start while busy and operand changes mid-run must not disturb
        launch(2'd0, 16'h0003, 16'h0004);
        pulses = 0; k = 0;
        while (!bus.done && k < 40) begin
            @(posedge clk); #1; k++;
            if (k == 4) begin bus.start = 1'b1; bus.data_in_A = 16'h1111; bus.data_in_B = 16'h2222; bus.op = 2'd3; end
            if (k == 5) bus.start = 1'b0;
            if (k == 9) bus.data_in_A = 16'h7777;
        end
        chk("ignore.latency", 32'(k), 32'd17);
        chk("ignore.hi", 32'(bus.hi_out), 32'h0);
        chk("ignore.lo", 32'(bus.lo_out), 32'h000C);
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        chk("ignore.no_extra_done", 32'(pulses), 32'd0);
        chk("ignore.idle", 32'(bus.busy), 32'd0);

        // back-to-back: start held high through done
        bus.start = 1'b1; bus.op = 2'd0; bus.data_in_A = 16'd5; bus.data_in_B = 16'd6;
        @(posedge clk); #1;
        bus.data_in_A = 16'd7; bus.data_in_B = 16'd9;
        wait_done(k);
        chk("b2b.first_latency", 32'(k), 32'd17);
        chk("b2b.first_lo", 32'(bus.lo_out), 32'd30);
        @(posedge clk); #1;
        chk("b2b.relaunch_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(k);
        chk("b2b.second_latency", 32'(k), 32'd17);
        chk("b2b.second_lo", 32'(bus.lo_out), 32'd63);
        @(posedge clk); #1;

        // reset mid-operation
        launch(2'd2, 16'd100, 16'd7);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        chk("midrst.hi", 32'(bus.hi_out), 32'd0);
        chk("midrst.lo", 32'(bus.lo_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        chk("midrst.no_done", 32'(pulses), 32'd0);
        run_op("post_rst_2x8", 2'd0, 16'd2, 16'd8);

        // randomized operations with corner-value operands mixed in
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 16'h0;
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
